// File: rtl/life_support_scheduler.sv
// life_support_scheduler: mode FSM plus round-robin power-bus arbiter
// driving mode, grant, chrg and o2sup for the life-support datapath.
module life_support_scheduler #(
   parameter int n         = 32,
   parameter int LOW_PWR   = 10,
   parameter int FULL_PWR  = 1000,
   parameter int SLOT      = 8,
   parameter int CLEAR_CYC = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         enable,
   input  logic         atk,
   input  logic         cmd_def,
   input  logic         cmd_sth,
   input  logic         fatal,
   input  logic [n-1:0] power,
   input  logic [2:0]   req,
   output logic [2:0]   grant,
   output logic [3:0]   mode,
   output logic         chrg,
   output logic         o2sup
);

   localparam int SW = $clog2(SLOT + 1);
   localparam int CW = $clog2(CLEAR_CYC + 1);
   localparam logic [n-1:0]  LOW_V  = n'(LOW_PWR);
   localparam logic [n-1:0]  FULL_V = n'(FULL_PWR);
   localparam logic [SW-1:0] SLOT_V = SW'(SLOT);
   localparam logic [CW-1:0] CLR_V  = CW'(CLEAR_CYC);

   typedef enum logic [2:0] {
      IDLE,
      NORMAL,
      DEFENCE,
      STEALTH,
      EMERGENCY
   } state_t;

   state_t        state;
   state_t        state_n;
   logic [CW-1:0] clr;
   logic [CW-1:0] clr_n;
   logic [SW-1:0] slot;
   logic [SW-1:0] slot_n;
   logic [1:0]    ptr;
   logic [1:0]    ptr_n;
   logic [2:0]    grant_n;
   logic [3:0]    mode_n;
   logic          chrg_n;
   logic          o2sup_n;
   logic          pwr_ok;
   logic          hot;
   logic [2:0]    mreq;
   logic [2:0]    cand;
   logic          held;
   logic          hold_ok;
   logic          expiring;
   logic          found;
   logic          take;
   logic [1:0]    pick;
   logic [1:0]    sel;
   int            idx;

   assign pwr_ok = (power >= LOW_V);
   assign hot    = atk | cmd_def;

   always_comb begin
      state_n = state;
      clr_n   = clr;
      if (!enable) begin
         state_n = IDLE;
         clr_n   = '0;
      end else begin
         unique case (state)
            IDLE: state_n = NORMAL;
            NORMAL: begin
               if (fatal) begin
                  state_n = EMERGENCY;
                  clr_n   = '0;
               end else if (hot && pwr_ok) begin
                  state_n = DEFENCE;
               end else if (cmd_sth && pwr_ok) begin
                  state_n = STEALTH;
               end
            end
            DEFENCE: begin
               if (fatal) begin
                  state_n = EMERGENCY;
                  clr_n   = '0;
               end else if (!(hot && pwr_ok)) begin
                  state_n = NORMAL;
               end
            end
            STEALTH: begin
               if (fatal) begin
                  state_n = EMERGENCY;
                  clr_n   = '0;
               end else if (atk && pwr_ok) begin
                  state_n = DEFENCE;
               end else if (!cmd_sth || !pwr_ok) begin
                  state_n = NORMAL;
               end
            end
            EMERGENCY: begin
               if (fatal) begin
                  clr_n = '0;
               end else begin
                  if (clr < CLR_V) clr_n = clr + 1'b1;
                  if (clr_n == CLR_V) state_n = NORMAL;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // Arbitration is judged against the mode being entered, so a newly
   // masked requester loses its grant on the same edge as the mode change.
   always_comb begin
      mreq = req;
      if (state_n == STEALTH) mreq[1] = 1'b0;
      held     = |(mreq & grant);
      hold_ok  = held && (slot < SLOT_V);
      expiring = held && !(slot < SLOT_V);
      cand     = mreq;
      if (expiring && ((mreq & ~grant) != 3'b000)) cand = mreq & ~grant;

      pick  = 2'd0;
      found = 1'b0;
      idx   = 0;
      if (state_n == EMERGENCY) begin
         found = |cand;
         pick  = cand[2] ? 2'd2 : (cand[0] ? 2'd0 : 2'd1);
      end else begin
         for (int k = 0; k < 3; k++) begin
            idx = (int'(ptr) + k) % 3;
            if (!found && cand[idx]) begin
               found = 1'b1;
               pick  = 2'(idx);
            end
         end
      end

      take    = 1'b0;
      sel     = pick;
      grant_n = '0;
      slot_n  = '0;
      ptr_n   = ptr;
      if (state_n != IDLE) begin
         if (state_n == DEFENCE && req[0] && !grant[0]) begin
            take = 1'b1;
            sel  = 2'd0;
         end else if (state_n == EMERGENCY && req[2] && !grant[2]) begin
            take = 1'b1;
            sel  = 2'd2;
         end else if (hold_ok) begin
            grant_n = grant;
            slot_n  = slot + 1'b1;
         end else if (found) begin
            take = 1'b1;
         end
      end
      if (take) begin
         grant_n = 3'b001 << sel;
         slot_n  = SW'(1);
         ptr_n   = (sel == 2'd2) ? 2'd0 : sel + 2'd1;
      end
   end

   always_comb begin
      unique case (state_n)
         IDLE:      mode_n = 4'b0000;
         NORMAL:    mode_n = 4'b0001;
         EMERGENCY: mode_n = 4'b0010;
         DEFENCE:   mode_n = 4'b0100;
         STEALTH:   mode_n = 4'b1000;
         default:   mode_n = 4'b0000;
      endcase
      chrg_n  = (state_n == EMERGENCY) ||
                (grant_n == 3'b000 && power < FULL_V && state_n != IDLE);
      o2sup_n = (state_n == EMERGENCY) || grant_n[2];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         clr   <= '0;
         slot  <= '0;
         ptr   <= 2'd0;
         grant <= 3'b000;
         mode  <= 4'b0000;
         chrg  <= 1'b0;
         o2sup <= 1'b0;
      end else begin
         state <= state_n;
         clr   <= clr_n;
         slot  <= slot_n;
         ptr   <= ptr_n;
         grant <= grant_n;
         mode  <= mode_n;
         chrg  <= chrg_n;
         o2sup <= o2sup_n;
      end
   end

endmodule

// File: tb/tb_life_support_scheduler.sv
// tb_life_support_scheduler: vector table, directed corner sequences and
// randomized traffic against a behavioural model of the scheduler.
module tb_life_support_scheduler;

   localparam int LOW_PWR   = 10;
   localparam int FULL_PWR  = 1000;
   localparam int SLOT      = 8;
   localparam int CLEAR_CYC = 16;
   localparam int ST_IDLE = 0;
   localparam int ST_NORM = 1;
   localparam int ST_DEF  = 2;
   localparam int ST_STH  = 3;
   localparam int ST_EMER = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        atk;
   logic        cmd_def;
   logic        cmd_sth;
   logic        fatal;
   logic [31:0] power;
   logic [2:0]  req;
   logic [2:0]  grant;
   logic [3:0]  mode;
   logic        chrg;
   logic        o2sup;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   life_support_scheduler #(
      .n(32), .LOW_PWR(LOW_PWR), .FULL_PWR(FULL_PWR),
      .SLOT(SLOT), .CLEAR_CYC(CLEAR_CYC)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .atk(atk),
      .cmd_def(cmd_def), .cmd_sth(cmd_sth), .fatal(fatal),
      .power(power), .req(req), .grant(grant), .mode(mode),
      .chrg(chrg), .o2sup(o2sup)
   );

   typedef struct {
      logic        en;
      logic        at;
      logic        cd;
      logic        cs;
      logic        ft;
      logic [31:0] pw;
      logic [2:0]  rq;
      logic [3:0]  md;
      logic [2:0]  gr;
      logic        ch;
      logic        o2;
   } vec_t;

   vec_t vecs[15];

   // behavioural reference state
   int         m_state;
   int         m_hold;
   int         m_slot;
   int         m_next;
   int         m_clr;
   logic [3:0] m_mode;
   logic [2:0] m_grant;
   logic       m_chrg;
   logic       m_o2;
   logic [3:0] mode_of[5] = '{4'b0000, 4'b0001, 4'b0100, 4'b1000, 4'b0010};

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic en, input logic at, input logic cd,
                         input logic cs, input logic ft,
                         input logic [31:0] pw, input logic [2:0] rq);
      enable  = en;
      atk     = at;
      cmd_def = cd;
      cmd_sth = cs;
      fatal   = ft;
      power   = pw;
      req     = rq;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 3'b000);
      #1;
      check("rst_mode", 32'(mode), 32'h0);
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_chrg", 32'(chrg), 32'h0);
      check("rst_o2sup", 32'(o2sup), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic model_reset();
      m_state = ST_IDLE;
      m_hold  = -1;
      m_slot  = 0;
      m_next  = 0;
      m_clr   = 0;
   endtask

   task automatic model_step();
      int       ns;
      bit       pok;
      bit       hot;
      bit [2:0] r;
      bit [2:0] others;
      bit       expiring;
      int       order[3];
      int       pick;
      pok = (power >= 32'(LOW_PWR));
      hot = atk || cmd_def;
      ns  = m_state;
      if (!enable) begin
         ns    = ST_IDLE;
         m_clr = 0;
      end else if (m_state == ST_IDLE) begin
         ns = ST_NORM;
      end else if (m_state == ST_EMER) begin
         if (fatal) begin
            m_clr = 0;
         end else begin
            m_clr++;
            if (m_clr >= CLEAR_CYC) begin
               m_clr = CLEAR_CYC;
               ns    = ST_NORM;
            end
         end
      end else if (fatal) begin
         ns    = ST_EMER;
         m_clr = 0;
      end else if (m_state == ST_NORM) begin
         if (hot && pok) ns = ST_DEF;
         else if (cmd_sth && pok) ns = ST_STH;
      end else if (m_state == ST_DEF) begin
         if (!(hot && pok)) ns = ST_NORM;
      end else begin
         if (atk && pok) ns = ST_DEF;
         else if (!cmd_sth || !pok) ns = ST_NORM;
      end

      r = req;
      if (ns == ST_STH) r[1] = 1'b0;
      pick = -1;
      if (ns == ST_IDLE) begin
         m_hold = -1;
         m_slot = 0;
      end else if (ns == ST_DEF && req[0] && m_hold != 0) begin
         pick = 0;
      end else if (ns == ST_EMER && req[2] && m_hold != 2) begin
         pick = 2;
      end else if (m_hold >= 0 && r[m_hold] && m_slot < SLOT) begin
         m_slot++;
      end else begin
         expiring = (m_hold >= 0) && r[m_hold];
         others = r;
         if (m_hold >= 0) others[m_hold] = 1'b0;
         if (ns == ST_EMER) order = '{2, 0, 1};
         else order = '{m_next, (m_next + 1) % 3, (m_next + 2) % 3};
         for (int k = 0; k < 3; k++) begin
            if (pick < 0 && r[order[k]] &&
                !(expiring && order[k] == m_hold && others != 3'b000))
               pick = order[k];
         end
         if (pick < 0) begin
            m_hold = -1;
            m_slot = 0;
         end
      end
      if (pick >= 0) begin
         m_hold = pick;
         m_slot = 1;
         m_next = (pick + 1) % 3;
      end

      m_state = ns;
      m_grant = (m_hold < 0) ? 3'b000 : 3'(3'b001 << m_hold);
      m_mode  = mode_of[ns];
      m_chrg  = (ns == ST_EMER) ||
                (m_grant == 3'b000 && power < 32'(FULL_PWR) && ns != ST_IDLE);
      m_o2    = (ns == ST_EMER) || m_grant[2];
   endtask

   initial begin
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd500,  3'b000, 4'b0001, 3'b000, 1'b1, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd500,  3'b000, 4'b0100, 3'b000, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd9,    3'b000, 4'b0001, 3'b000, 1'b1, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd500,  3'b010, 4'b1000, 3'b000, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd500,  3'b011, 4'b1000, 3'b001, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd500,  3'b011, 4'b0100, 3'b001, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd500,  3'b010, 4'b0100, 3'b010, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd500,  3'b011, 4'b0100, 3'b001, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd500,  3'b110, 4'b0001, 3'b010, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd500,  3'b110, 4'b0010, 3'b100, 1'b1, 1'b1};
      vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2000, 3'b000, 4'b0010, 3'b000, 1'b1, 1'b1};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd500,  3'b111, 4'b0000, 3'b000, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2000, 3'b000, 4'b0001, 3'b000, 1'b0, 1'b0};
      vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1000, 3'b100, 4'b0001, 3'b100, 1'b0, 1'b1};
      vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd999,  3'b000, 4'b0001, 3'b000, 1'b1, 1'b0};

      rst = 1'b0;
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 3'b000);
      #2;
      do_reset();

      for (int i = 0; i < 15; i++) begin
         set_in(vecs[i].en, vecs[i].at, vecs[i].cd, vecs[i].cs,
                vecs[i].ft, vecs[i].pw, vecs[i].rq);
         step();
         check($sformatf("vec%0d_mode", i), 32'(mode), 32'(vecs[i].md));
         check($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].gr));
         check($sformatf("vec%0d_chrg", i), 32'(chrg), 32'(vecs[i].ch));
         check($sformatf("vec%0d_o2sup", i), 32'(o2sup), 32'(vecs[i].o2));
      end

      // power-up then three-way rotation with full slots
      do_reset();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd500, 3'b000);
      step();
      check("up_mode", 32'(mode), 32'h1);
      check("up_chrg", 32'(chrg), 32'h1);
      check("up_grant", 32'(grant), 32'h0);
      req = 3'b111;
      for (int k = 0; k < 40; k++) begin
         step();
         check($sformatf("rot%0d_grant", k), 32'(grant),
               32'(3'b001 << ((k / SLOT) % 3)));
         check($sformatf("rot%0d_onehot", k), 32'($onehot0(grant)), 32'h1);
      end

      // emergency entry, interrupted clearing, then full clear
      req   = 3'b000;
      fatal = 1'b1;
      step();
      check("emer_mode", 32'(mode), 32'h2);
      check("emer_o2sup", 32'(o2sup), 32'h1);
      check("emer_chrg", 32'(chrg), 32'h1);
      fatal = 1'b0;
      for (int k = 0; k < CLEAR_CYC - 1; k++) begin
         step();
         check($sformatf("clr_a%0d_mode", k), 32'(mode), 32'h2);
      end
      fatal = 1'b1;
      step();
      check("refatal_mode", 32'(mode), 32'h2);
      fatal = 1'b0;
      for (int k = 0; k < CLEAR_CYC; k++) begin
         step();
         check($sformatf("clr_b%0d_mode", k), 32'(mode),
               (k == CLEAR_CYC - 1) ? 32'h1 : 32'h2);
      end

      // disable mid-grant, then async reset mid-emergency
      req = 3'b001;
      step();
      check("midg_grant", 32'(grant), 32'h1);
      enable = 1'b0;
      step();
      check("dis_mode", 32'(mode), 32'h0);
      check("dis_grant", 32'(grant), 32'h0);
      enable = 1'b1;
      req    = 3'b100;
      fatal  = 1'b1;
      step();
      step();
      check("pre_rst_mode", 32'(mode), 32'h2);
      check("pre_rst_grant", 32'(grant), 32'h4);
      #2;
      do_reset();

      // randomized traffic against the reference model
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         enable = ($urandom_range(0, 99) != 0);
         fatal  = ($urandom_range(0, 39) == 0);
         atk    = ($urandom_range(0, 3) == 0);
         cmd_def = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 7) == 0) cmd_sth = ~cmd_sth;
         if ($urandom_range(0, 5) == 0) req = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 5))
            0: power = 32'($urandom_range(0, 9));
            1: power = 32'd10;
            2: power = 32'd9;
            3: power = 32'd999;
            4: power = 32'd1000;
            default: power = $urandom;
         endcase
         @(posedge clk);
         model_step();
         #1;
         check("rnd_mode", 32'(mode), 32'(m_mode));
         check("rnd_grant", 32'(grant), 32'(m_grant));
         check("rnd_chrg", 32'(chrg), 32'(m_chrg));
         check("rnd_o2sup", 32'(o2sup), 32'(m_o2));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
